// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, status codes and command bytes for the PS/2 host transmitter
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, START, BITS, ACK, WAIT_IDLE, FINISH} ps2_state_e;
  localparam logic [1:0] PS2_OK = 2'd0;
  localparam logic [1:0] PS2_ERR_START = 2'd1;
  localparam logic [1:0] PS2_ERR_XFER = 2'd2;
  localparam logic [1:0] PS2_ERR_NOACK = 2'd3;
  localparam logic [7:0] PS2_CMD_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_EN = 8'hF4;
  localparam int TMR_W = 21;
  localparam int INH_W = 14;
  localparam int BIT_W = 4;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, consecutive-sample glitch filter and falling-edge strobe
module ps2_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILT_LEN) + 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // Idle PS/2 lines are pulled high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sync[1];
        cnt <= '0;
        fall <= level;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter; request-to-send, clocked-out frame, ACK check
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES = 16,
  parameter int START_TIMEOUT = 1_500_000,
  parameter int XFER_TIMEOUT = 200_000,
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_valid,
  input  logic [7:0] tx_data,
  output logic tx_ready,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe,
  output logic busy,
  output logic done,
  output logic [1:0] err
);
  ps2_state_e state, state_n;
  logic [1:0] err_n;
  logic [7:0] data;
  logic par, cur;
  logic [INH_W-1:0] ic;
  logic [TMR_W-1:0] tmr;
  logic [BIT_W-1:0] n;
  logic clk_lvl, clk_fall, data_lvl, unused_data_fall;
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk (
    .clk(clk), .rst(rst), .raw(ps2_clk_in), .level(clk_lvl), .fall(clk_fall)
  );
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data (
    .clk(clk), .rst(rst), .raw(ps2_data_in), .level(data_lvl), .fall(unused_data_fall)
  );
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign done = state == FINISH;
  assign cur = n[3] ? par : data[n[2:0]];
  // Outputs decode straight from the state register so an async reset drops them at once.
  assign ps2_clk_oe = state == INHIBIT || state == REQ;
  assign ps2_data_oe = state == REQ || state == START || (state == BITS && ~cur);
  always_comb begin
    state_n = state;
    err_n = err;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = INHIBIT;
        err_n = PS2_OK;
      end
      INHIBIT: state_n = ic >= INH_W'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
      REQ: state_n = ic >= INH_W'(REQ_CYCLES - 1) ? START : REQ;
      START: if (clk_fall) state_n = BITS;
        else if (tmr >= TMR_W'(START_TIMEOUT - 1)) begin
          state_n = FINISH;
          err_n = PS2_ERR_START;
        end
      BITS: if (tmr >= TMR_W'(XFER_TIMEOUT - 1)) begin
          state_n = FINISH;
          err_n = PS2_ERR_XFER;
        end else if (clk_fall && n == BIT_W'(8)) state_n = ACK;
      ACK: if (tmr >= TMR_W'(XFER_TIMEOUT - 1)) begin
          state_n = FINISH;
          err_n = PS2_ERR_XFER;
        end else if (clk_fall) begin
          state_n = data_lvl ? FINISH : WAIT_IDLE;
          err_n = data_lvl ? PS2_ERR_NOACK : err;
        end
      WAIT_IDLE: state_n = clk_lvl && data_lvl ? FINISH : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  // The transfer timer restarts on fall 1 (START -> BITS) and keeps running through ACK.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      err <= PS2_OK;
      data <= '0;
      par <= 1'b0;
      ic <= '0;
      tmr <= '0;
      n <= '0;
    end else begin
      state <= state_n;
      err <= err_n;
      if (tx_valid && tx_ready) begin
        data <= tx_data;
        par <= ~^tx_data;
      end
      ic <= state_n != state ? '0 : ic + INH_W'(ic != '1);
      tmr <= (state_n != state && (state_n == START || state_n == BITS)) ? '0 : tmr + TMR_W'(tmr != '1);
      n <= state == START ? '0 : n + BIT_W'(state == BITS && clk_fall && n != '1);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a 40-cycle PS/2 device model on open-collector lines
module tb_ps2_host_tx;
  logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
  logic [1:0] err;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in;
  int errors = 0, checks = 0;
  int ndone = 0;
  logic [1:0] derr, dlines;
  logic prev_coe = 1'b0, prev_doe = 1'b0;
  int coe_len = 0, dly = -1, since = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(40), .REQ_CYCLES(4), .START_TIMEOUT(500), .XFER_TIMEOUT(2000), .FILT_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Records each done pulse and the line-release timing of the request-to-send phase.
  always @(negedge clk) begin
    if (done) begin
      ndone = ndone + 1;
      derr = err;
      dlines = {ps2_clk_oe, ps2_data_oe};
    end
    if (ps2_clk_oe && !prev_coe) begin
      coe_len = 0;
      dly = -1;
      since = 0;
    end
    if (ps2_clk_oe) coe_len = coe_len + 1;
    if (ps2_data_oe && !prev_doe && ps2_clk_oe) dly = since;
    if (ps2_clk_oe) since = since + 1;
    prev_coe = ps2_clk_oe;
    prev_doe = ps2_data_oe;
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int c = 0;
    while (!ps2_clk_oe && c < 2000) begin @(negedge clk); c++; end
    while (ps2_clk_oe && c < 2000) begin @(negedge clk); c++; end
    ok = c < 2000;
  endtask

  // Device: waits for clock release, then nclk clock pulses; samples data mid-high.
  task automatic dev_frame(input int nclk, input bit ack, input bit glitch, output logic [10:0] b);
    bit ok;
    b = '1;
    wait_release(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dev_release: clk_oe still %0b, want 0", ps2_clk_oe);
      return;
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      b[i] = ps2_data_in;
      if (i == 9 && ack) dev_data = 1'b0;
      if (i == 10) dev_data = 1'b1;
      if (glitch && i == 3) begin
        repeat (3) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
      end else repeat (15) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int n0);
    int c = 0;
    while (ndone == n0 && c < 4000) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", tx_ready, busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 2'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err); end
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_led;
    logic [10:0] b;
    int n0 = ndone;
    send(8'hED);
    dev_frame(11, 1'b1, 1'b0, b);
    wait_done(n0);
    checks += 4;
    if (b[9:0] !== 10'b11_1110_1101) begin errors++; $display("FAIL led_bits: got %b want 1111101101", b[9:0]); end
    if (ndone - n0 != 1) begin errors++; $display("FAIL led_done: got %0d pulses want 1", ndone - n0); end
    if (derr !== 2'd0) begin errors++; $display("FAIL led_err: got %0d want 0", derr); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL led_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_en;
    logic [10:0] b;
    int n0 = ndone;
    send(8'hF4);
    dev_frame(11, 1'b1, 1'b0, b);
    wait_done(n0);
    checks += 4;
    if (b[9:0] !== 10'b10_1111_0100) begin errors++; $display("FAIL en_bits: got %b want 1011110100", b[9:0]); end
    if (coe_len != 44) begin errors++; $display("FAIL en_clk_oe_len: got %0d want 44", coe_len); end
    if (dly != 40) begin errors++; $display("FAIL en_data_oe_delay: got %0d want 40", dly); end
    if (derr !== 2'd0 || ndone - n0 != 1) begin errors++; $display("FAIL en_status: err=%0d pulses=%0d want 0/1", derr, ndone - n0); end
  endtask

  task automatic test_start_timeout;
    bit ok;
    int c = 0;
    send(8'hF4);
    wait_release(ok);
    while (!done && c < 1000) begin @(negedge clk); c++; end
    checks += 4;
    if (!ok || c != 500) begin errors++; $display("FAIL start_timeout_cycles: got %0d want 500", c); end
    if (err !== 2'd1) begin errors++; $display("FAIL start_timeout_err: got %0d want 1", err); end
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL start_timeout_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    @(negedge clk);
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL start_timeout_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_xfer_timeout;
    logic [10:0] b;
    int n0 = ndone;
    send(8'hED);
    dev_frame(5, 1'b0, 1'b0, b);
    wait_done(n0);
    checks += 3;
    if (ndone - n0 != 1) begin errors++; $display("FAIL xfer_done: got %0d pulses want 1", ndone - n0); end
    if (derr !== 2'd2) begin errors++; $display("FAIL xfer_err: got %0d want 2", derr); end
    if (dlines !== 2'b00) begin errors++; $display("FAIL xfer_oe: got %b want 00", dlines); end
  endtask

  task automatic test_noack;
    logic [10:0] b;
    int n0 = ndone;
    send(8'hED);
    dev_frame(11, 1'b0, 1'b0, b);
    wait_done(n0);
    checks += 2;
    if (derr !== 2'd3 || ndone - n0 != 1) begin errors++; $display("FAIL noack_err: err=%0d pulses=%0d want 3/1", derr, ndone - n0); end
    if (dlines !== 2'b00) begin errors++; $display("FAIL noack_oe: got %b want 00", dlines); end
  endtask

  task automatic test_busy_glitch;
    logic [10:0] b;
    logic rdy = 1'b1;
    int n0 = ndone;
    send(8'hED);
    fork
      dev_frame(11, 1'b1, 1'b1, b);
      begin
        repeat (150) @(negedge clk);
        rdy = tx_ready;
        tx_valid = 1'b1;
        tx_data = 8'h00;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_done(n0);
    checks += 4;
    if (rdy !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", rdy); end
    if (b[9:0] !== 10'b11_1110_1101) begin errors++; $display("FAIL busy_bits: got %b want 1111101101", b[9:0]); end
    if (ndone - n0 != 1) begin errors++; $display("FAIL busy_done: got %0d pulses want 1", ndone - n0); end
    if (derr !== 2'd0) begin errors++; $display("FAIL busy_err: got %0d want 0", derr); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] b;
    logic pre;
    int n0;
    send(8'hF4);
    dev_frame(2, 1'b0, 1'b0, b);
    pre = ps2_data_oe;
    n0 = ndone;
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (pre !== 1'b1) begin errors++; $display("FAIL rst_pre_data_oe: got %b want 1", pre); end
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL rst_async_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_ready: ready=%b busy=%b want 1/0", tx_ready, busy); end
    if (ndone != n0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone - n0); end
    n0 = ndone;
    send(8'hF4);
    dev_frame(11, 1'b1, 1'b0, b);
    wait_done(n0);
    checks += 2;
    if (b[9:0] !== 10'b10_1111_0100) begin errors++; $display("FAIL rst_after_bits: got %b want 1011110100", b[9:0]); end
    if (derr !== 2'd0 || ndone - n0 != 1) begin errors++; $display("FAIL rst_after_status: err=%0d pulses=%0d want 0/1", derr, ndone - n0); end
  endtask

  initial begin
    test_reset;
    test_led;
    test_en;
    test_start_timeout;
    test_xfer_timeout;
    test_noack;
    test_busy_glitch;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
